uart_rx_pair: RTL

- UART 8N1 receiver that feeds the ID stage's UART input interface (uart_signal / uart_flag / uart_rx_data).
- Deserialises bytes from the external rx pin and presents each good byte with a one-cycle strobe.
- Tags bytes alternately 0/1 so the register file fills uart_register1, then uart_register2.
- Sits between the board pin and ID; one clock domain with the CPU.

---
 rtl/uart_rx_pair.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_pair.sv
// 8N1 UART receiver: byte strobe lands ~SYNC_STAGES + BAUD_DIV/2 + 9*BAUD_DIV cycles after the start edge.
// No backpressure; the pair tag alternates 0/1 on each good byte.
module uart_rx_pair #(
  parameter int BAUD_DIV    = 5208,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       uart_signal,
  output logic       uart_flag,
  output logic [7:0] uart_rx_data,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [15:0] HALF_LIM = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_LIM = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   flag_q, flag_d;
  logic                   pair_q, pair_d;
  logic                   sig_q, sig_d;
  logic                   ferr_q, ferr_d;
  logic                   rx_s;
  logic [15:0]            limit;
  logic                   tick;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s  = sync_q[SYNC_STAGES-1];
  assign limit = (state_q == S_START) ? HALF_LIM : FULL_LIM;
  assign tick  = (cnt_q == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      flag_q    <= 1'b0;
      pair_q    <= 1'b0;
      sig_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      flag_q    <= flag_d;
      pair_q    <= pair_d;
      sig_q     <= sig_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? 16'd0 : cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    flag_d    = flag_q;
    pair_d    = pair_q;
    sig_d     = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            data_d  = shift_q;
            flag_d  = pair_q;
            sig_d   = 1'b1;
            pair_d  = ~pair_q;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign uart_signal  = sig_q;
  assign uart_flag    = flag_q;
  assign uart_rx_data = data_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule
